mux2_rr_arbiter: RTL
====================

Name: mux2_rr_arbiter

Overview:
- Sequences and shares one 2:1 output mux between two requesters (ch0, ch1) using round-robin arbitration.
- A burst limit bounds how long either requester holds the mux.
- Drives the mux select and gates the per-beat handshake with the downstream consumer.
- Sits in front of the shared datapath. The 2:1 mux is instantiated internally, with `sel_o` as its select.

Parameters:
- DATA_W, 8, width of each data input and of the muxed output
- MAX_BURST, 4, max beats transferred per grant while the other requester waits (legal range 1..255)

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  synchronous reset, active-high
- req0_i  input  1  ch0 requests/holds the mux; data0_i valid while high
- req1_i  input  1  ch1 requests/holds the mux; data1_i valid while high
- data0_i  input  DATA_W  ch0 beat data
- data1_i  input  DATA_W  ch1 beat data
- out_ready_i  input  1  downstream accepts a beat this cycle
- gnt0_o  output  1  ch0 owns the mux (registered)
- gnt1_o  output  1  ch1 owns the mux (registered)
- ack0_o  output  1  ch0 beat accepted this cycle
- ack1_o  output  1  ch1 beat accepted this cycle
- sel_o  output  1  mux select; 0=ch0, 1=ch1 (registered)
- out_valid_o  output  1  muxed beat valid
- out_data_o  output  DATA_W  muxed data
- busy_o  output  1  a grant is active

Behaviour:
- States: IDLE, GRANT0, GRANT1.
  - gnt0_o = (state==GRANT0); gnt1_o = (state==GRANT1); busy_o = gnt0_o | gnt1_o.
- Internal registers:
  - last: last granted channel, reset value 1.
  - cnt: beat counter, width $clog2(MAX_BURST+1), reset value 0.
- Reset values (rst_i high at any clock edge, including mid-burst):
  - state=IDLE, sel_o=0, cnt=0, last=1.
  - All grants and acks are 0 in the same cycle, because they derive from state.
  - Any in-flight burst is abandoned with no further acks.
- Combinational outputs:
  - out_data_o = sel_o ? data1_i : data0_i (2:1 mux).
  - out_valid_o = (gnt0_o & req0_i) | (gnt1_o & req1_i).
  - ack0_o = gnt0_o & req0_i & out_ready_i; ack1_o likewise.
  - A beat transfers when its ack is high.
- IDLE:
  - No request: stay in IDLE; sel_o holds.
  - Exactly one request: grant that channel on the next edge.
  - Both requesting: grant the channel != last.
  - On grant: sel_o, last ← granted channel; cnt ← 0.
  - Arbitration latency is 1 cycle (request at edge N → grant visible after edge N+1).
- GRANTx, own request low:
  - No transfer this cycle.
  - If the other channel requests: go directly to GRANT(other), with sel_o/last updated and cnt=0 (no IDLE bubble). Otherwise go to IDLE.
- GRANTx, transfer, cnt < MAX_BURST-1: cnt++ and stay in GRANTx.
- GRANTx, transfer, cnt == MAX_BURST-1 (burst limit reached):
  - Other channel requesting: switch to GRANT(other), cnt=0.
  - Otherwise stay in GRANTx with cnt=0 (grant extended).
- GRANTx, request high, out_ready_i low: stall. Hold state and cnt; out_valid_o stays high.
- Simultaneous events:
  - Own request drop and limit expiry cannot coincide with a transfer, because a drop means no ack.
  - The other channel's request arriving in the same cycle as the limit beat is honoured.
- MAX_BURST=1: alternate every beat while both request.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined:
  - IDLE ties always go to ch0.
  - `last` is ignored for arbitration.
  - The burst limit still forces a hand-over to a waiting ch1.
- Undefined: round-robin as above.

Test Plan:
- Reset then req0=1 only, out_ready=1 → gnt0 one cycle later, sel_o=0, ack0 every cycle; after 4 beats, with req1=0, grant is kept and cnt wraps to 0.
- req0=req1=1 from IDLE after reset → gnt0 first (last=1). After beats 1–4 ack0, gnt1 next cycle with sel_o=1; 4 acks on ch1, then back to ch0. No idle cycle between grants.
- Grant ch1, out_ready toggled 1,0,0,1,1,1 → exactly 4 ack1 pulses, stall cycles hold cnt, out_valid_o=1 throughout, out_data_o=data1_i (e.g. 8'hA5).
- Grant ch0 after 2 beats, req0 drops while req1=1 → gnt1 next cycle, cnt=0; req1 drops with req0=0 → IDLE, busy_o=0, sel_o stays 1.
- rst_i pulsed mid-burst (cnt=2, GRANT1) → next cycle all grants/acks 0, sel_o=0. With both requesting after reset, ch0 is granted first.
- ARB_FIXED_PRIO_EN defined, both requests held, MAX_BURST=2 → grants alternate 0,0,1,1,0,0. From IDLE with both arriving together after ch0 was last, ch0 still wins.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
// Round-robin owner of a shared 2:1 mux with per-grant burst limit; 1-cycle arbitration, stalls on out_ready_i low.
// Define ARB_FIXED_PRIO_EN to resolve idle ties in favour of ch0 instead of round-robin.
module mux2_rr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic [DATA_W-1:0] data0_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic              out_ready_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic              sel_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              busy_o
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {S_IDLE, S_GNT0, S_GNT1} state_t;

  state_t        state_q, state_d;
  logic          sel_q, sel_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tie_pick;
  logic          own_req, oth_req, xfer;
  logic          grant, pick;

`ifdef ARB_FIXED_PRIO_EN
  assign tie_pick = 1'b0;
`else
  assign tie_pick = ~last_q;
`endif

  assign gnt0_o      = (state_q == S_GNT0);
  assign gnt1_o      = (state_q == S_GNT1);
  assign busy_o      = gnt0_o | gnt1_o;
  assign sel_o       = sel_q;
  assign out_data_o  = sel_q ? data1_i : data0_i;
  assign out_valid_o = (gnt0_o & req0_i) | (gnt1_o & req1_i);
  assign ack0_o      = gnt0_o & req0_i & out_ready_i;
  assign ack1_o      = gnt1_o & req1_i & out_ready_i;

  // Only meaningful while a grant is held; sel_q then names the owner.
  assign own_req = gnt0_o ? req0_i : req1_i;
  assign oth_req = gnt0_o ? req1_i : req0_i;
  assign xfer    = ack0_o | ack1_o;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    grant   = 1'b0;
    pick    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0_i | req1_i) begin
          grant = 1'b1;
          pick  = (req0_i & req1_i) ? tie_pick : req1_i;
        end
      end
      S_GNT0, S_GNT1: begin
        if (!own_req) begin
          if (oth_req) begin
            grant = 1'b1;
            pick  = ~sel_q;
          end else begin
            state_d = S_IDLE;
          end
        end else if (xfer) begin
          if (cnt_q == LIMIT) begin
            // Limit beat: hand over if the other side waits, else extend with a fresh count.
            cnt_d = '0;
            if (oth_req) begin
              grant = 1'b1;
              pick  = ~sel_q;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (grant) begin
      state_d = pick ? S_GNT1 : S_GNT0;
      sel_d   = pick;
      last_d  = pick;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
